operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Operand-fetch stage directly upstream of the 16-bit ALU. Decodes a 16-bit instruction word,
//  reads two source registers from an internal 16x16 register file, and presents the opcode
//  plus both operands to the ALU through one registered stage with a valid/ready handshake.
//  Accepts a writeback port, fed from the ALU result path, that updates the register file.
// PARAMETERS
//  DW      16   data width, equal to the ALU operand width
//  NREG    16   number of architectural registers; address width is log2(NREG) = 4
//  OPW     4    opcode width, equal to the ALU opcode width
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous reset, active low
//  in_valid   in   1    instr is valid this cycle
//  in_ready   out  1    stage can accept instr this cycle
//  instr      in   16   [15:12]=opc, [11:8]=rd, [7:4]=rs, [3:0]=rt
//  out_valid  out  1    op_a/op_b/opc/rd hold a valid issue
//  out_ready  in   1    ALU/downstream consumes the issue this cycle
//  op_a       out  DW   value of register rs; drives the ALU A input
//  op_b       out  DW   value of register rt; drives the ALU B input
//  opc        out  OPW  opcode passed through to the ALU
//  rd         out  4    destination register, carried forward to writeback
//  wb_en      in   1    register-file write enable
//  wb_addr    in   4    write address
//  wb_data    in   DW   write data (ALU result)
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): all 16 registers=0; out_valid=0; op_a=op_b=0; opc=0; rd=0.
//  - in_ready = !out_valid | out_ready (combinational).
//  - An issue is accepted when in_valid & in_ready. The output register loads on the next
//    rising edge, so latency is 1 cycle from acceptance to out_valid=1.
//  - Stall: while out_valid & !out_ready, all outputs hold stable and no instr is accepted.
//  - out_valid clears on an edge where out_valid & out_ready & !in_valid.
//    Back-to-back issue with out_ready=1 gives 1 issue per cycle.
//  - Register r0 always reads 0. A write to r0 is discarded.
//  - Writeback: when wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data at the rising edge.
//    A writeback is accepted in any cycle, including stall cycles.
//  - Bypass: when wb_en=1, wb_addr!=0, and wb_addr equals rs (or rt) of an instr accepted
//    in the same cycle, the captured operand is wb_data and not the stale register value.
//    The bypass applies independently to A and B, and to both when rs=rt=wb_addr.
//  - Held outputs are not refreshed by a later writeback. The captured operand is final.
//  - All opcodes are passed through without checking. Invalid opcodes are the ALU's concern.
//  - When reset asserts mid-stall, the pending issue is dropped and out_valid=0 immediately.
//  - No combinational path from out_ready to out_valid or to the data outputs.
// STRUCTURE
//  - Shared package alu_pkg:
//      OP_ADD=4'b0000, OP_SUB=4'b0001, OP_SLT=4'b0010, OP_OR=4'b0011, OP_AND=4'b0100, OP_SHL=4'b0101
//      instr field positions (OPC_MSB/LSB, RD/RS/RT_MSB/LSB)
//      DW and REG_AW constants
//  - One sub-module reg_file:
//      16xDW storage, 2 combinational read ports, 1 synchronous write port
//      r0 forced to zero, same-cycle write-to-read bypass, async active-low clear
//  - Top level holds the handshake logic and the output pipeline register only.
// TESTING
//  1 Reset, then in_valid=0: out_valid=0, op_a=op_b=0, in_ready=1. Assert rst_n low mid-stall
//    -> out_valid=0 before the next edge.
//  2 Writeback r3=16'h0012 and r4=16'h0034, then issue instr 16'h1_5_3_4 with out_ready=1
//    -> next cycle out_valid=1, opc=1, rd=5, op_a=16'h0012, op_b=16'h0034.
//  3 Issue instr rs=r0 after wb_en with wb_addr=0, wb_data=16'hFFFF -> op_a=0.
//    r0 still reads 0 on the following issue.
//  4 Same cycle: wb_en=1, wb_addr=7, wb_data=16'hBEEF, and accept instr rs=7, rt=7
//    -> op_a=op_b=16'hBEEF.
//  5 Hold out_ready=0 for 3 cycles with in_valid=1 and a wb to the held rs
//    -> in_ready=0, outputs unchanged for 3 cycles.
//    Then raise out_ready -> next instr is issued with the updated register value.
//  6 Stream 8 instrs with out_ready=1 -> 8 consecutive out_valid cycles, order and operands correct.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: widths, opcode encodings, instruction field layout and decode.
package alu_pkg;

    localparam int unsigned DW     = 16;
    localparam int unsigned NREG   = 16;
    localparam int unsigned REG_AW = $clog2(NREG);
    localparam int unsigned OPW    = 4;
    localparam int unsigned IW     = 16;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS_MSB  = 7;
    localparam int unsigned RS_LSB  = 4;
    localparam int unsigned RT_MSB  = 3;
    localparam int unsigned RT_LSB  = 0;

    typedef enum logic [OPW-1:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_SLT = 4'b0010,
        OP_OR  = 4'b0011,
        OP_AND = 4'b0100,
        OP_SHL = 4'b0101
    } alu_op_e;

    typedef struct packed {
        logic [OPW-1:0]    opc;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } instr_t;

    typedef struct packed {
        logic [OPW-1:0]    opc;
        logic [REG_AW-1:0] rd;
        logic [DW-1:0]     op_a;
        logic [DW-1:0]     op_b;
    } issue_t;

    // Field extraction; opcode is passed through unchecked.
    function automatic instr_t decode(input logic [IW-1:0] w);
        instr_t d;
        d.opc = w[OPC_MSB:OPC_LSB];
        d.rd  = w[RD_MSB:RD_LSB];
        d.rs  = w[RS_MSB:RS_LSB];
        d.rt  = w[RT_MSB:RT_LSB];
        return d;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Issue-in, issue-out and writeback signals of the operand-fetch stage.
interface operand_fetch_if;
    import alu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [IW-1:0]       instr;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       op_a;
    logic [DW-1:0]       op_b;
    logic [OPW-1:0]      opc;
    logic [REG_AW-1:0]   rd;
    logic                wb_en;
    logic [REG_AW-1:0]   wb_addr;
    logic [DW-1:0]       wb_data;

    modport master (
        output in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, op_a, op_b, opc, rd
    );

    modport slave (
        input  in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, op_a, op_b, opc, rd
    );

endinterface

// File: rtl/reg_file.sv
// 16xDW register file: two combinational read ports with write bypass, one write port, r0 hardwired to 0.
module reg_file
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DW-1:0]     wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DW-1:0]     rdata_a_c,
    output logic [DW-1:0]     rdata_b_c
);

    logic [DW-1:0] mem_q [NREG];
    logic          wr_c;

    assign wr_c = we_i && (waddr_i != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_c) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-cycle writeback wins over the stale stored value.
    always_comb begin
        rdata_a_c = mem_q[raddr_a_i];
        if (raddr_a_i == '0) begin
            rdata_a_c = '0;
        end else if (wr_c && (waddr_i == raddr_a_i)) begin
            rdata_a_c = wdata_i;
        end
    end

    always_comb begin
        rdata_b_c = mem_q[raddr_b_i];
        if (raddr_b_i == '0) begin
            rdata_b_c = '0;
        end else if (wr_c && (waddr_i == raddr_b_i)) begin
            rdata_b_c = wdata_i;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: decode, register read, and one registered valid/ready issue slot to the ALU.
module operand_fetch
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    operand_fetch_if.slave  bus
);

    instr_t        dec_c;
    logic          accept_c;
    logic [DW-1:0] rf_a_c;
    logic [DW-1:0] rf_b_c;

    logic          out_valid_q, out_valid_d;
    issue_t        issue_q, issue_d;

    assign dec_c       = decode(bus.instr);
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept_c    = bus.in_valid && bus.in_ready;

    reg_file u_reg_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (bus.wb_en),
        .waddr_i   (bus.wb_addr),
        .wdata_i   (bus.wb_data),
        .raddr_a_i (dec_c.rs),
        .raddr_b_i (dec_c.rt),
        .rdata_a_c (rf_a_c),
        .rdata_b_c (rf_b_c)
    );

    // Load on accept, drain on consume, otherwise hold; held operands are never refreshed.
    always_comb begin
        out_valid_d = out_valid_q;
        issue_d     = issue_q;
        if (accept_c) begin
            out_valid_d  = 1'b1;
            issue_d.opc  = dec_c.opc;
            issue_d.rd   = dec_c.rd;
            issue_d.op_a = rf_a_c;
            issue_d.op_b = rf_b_c;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            issue_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            issue_q     <= issue_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.op_a      = issue_q.op_a;
    assign bus.op_b      = issue_q.op_b;
    assign bus.opc       = issue_q.opc;
    assign bus.rd        = issue_q.rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a register model predicts each issue, checked when it leaves.
module tb_operand_fetch;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    operand_fetch_if ifc ();

    operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    typedef struct packed {
        logic [3:0]  opc;
        logic [3:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mdl_rf [16];
    exp_t        mon_e;
    logic        mon_rdy;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] d,
                                       input logic [3:0] s, input logic [3:0] t);
        return {op, d, s, t};
    endfunction

    // Drive one cycle of inputs, then settle just after the capturing edge.
    task automatic step(input logic iv, input logic [15:0] ins, input logic ordy,
                        input logic we, input logic [3:0] wa, input logic [15:0] wd);
        ifc.in_valid  = iv;
        ifc.instr     = ins;
        ifc.out_ready = ordy;
        ifc.wb_en     = we;
        ifc.wb_addr   = wa;
        ifc.wb_data   = wd;
        @(posedge clk);
        #1;
    endtask

    // Monitor/model: sample mid-cycle, check the held issue, retire, update model, predict.
    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                sb_q.delete();
                for (int i = 0; i < 16; i++) mdl_rf[i] = 16'h0;
            end else begin
                check("out_valid", 16'(ifc.out_valid), 16'(sb_q.size() != 0));
                mon_rdy = (sb_q.size() == 0) || ifc.out_ready;
                check("in_ready", 16'(ifc.in_ready), 16'(mon_rdy));
                if (sb_q.size() != 0) begin
                    check("sb_opc",  16'(ifc.opc), 16'(sb_q[0].opc));
                    check("sb_rd",   16'(ifc.rd),  16'(sb_q[0].rd));
                    check("sb_op_a", ifc.op_a,     sb_q[0].a);
                    check("sb_op_b", ifc.op_b,     sb_q[0].b);
                    if (ifc.out_ready) void'(sb_q.pop_front());
                end
                if (ifc.wb_en && ifc.wb_addr != 4'h0) mdl_rf[ifc.wb_addr] = ifc.wb_data;
                if (ifc.in_valid && mon_rdy) begin
                    mon_e.opc = ifc.instr[15:12];
                    mon_e.rd  = ifc.instr[11:8];
                    mon_e.a   = (ifc.instr[7:4] == 4'h0) ? 16'h0 : mdl_rf[ifc.instr[7:4]];
                    mon_e.b   = (ifc.instr[3:0] == 4'h0) ? 16'h0 : mdl_rf[ifc.instr[3:0]];
                    sb_q.push_back(mon_e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ins;
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.instr     = 16'h0;
        ifc.out_ready = 1'b0;
        ifc.wb_en     = 1'b0;
        ifc.wb_addr   = 4'h0;
        ifc.wb_data   = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 16'(ifc.out_valid), 16'h0);
        check("rst_op_a", ifc.op_a, 16'h0);
        check("rst_op_b", ifc.op_b, 16'h0);
        check("rst_opc", 16'(ifc.opc), 16'h0);
        check("rst_rd", 16'(ifc.rd), 16'h0);
        check("rst_in_ready", 16'(ifc.in_ready), 16'h1);
        rst_n = 1'b1;

        // Reset asserted while an issue is stalled.
        step(1'b0, 16'h0, 1'b0, 1'b1, 4'd2, 16'h0055);
        step(1'b1, mk(OP_ADD, 4'd1, 4'd2, 4'd2), 1'b0, 1'b0, 4'd0, 16'h0);
        check("pre_rst_op_a", ifc.op_a, 16'h0055);
        step(1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_stall_rst_valid", 16'(ifc.out_valid), 16'h0);
        check("mid_stall_rst_op_a", ifc.op_a, 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, mk(OP_ADD, 4'd1, 4'd2, 4'd2), 1'b1, 1'b0, 4'd0, 16'h0);
        check("rf_cleared_r2", ifc.op_a, 16'h0);

        // Basic issue after two writebacks.
        step(1'b0, 16'h0, 1'b1, 1'b1, 4'd3, 16'h0012);
        step(1'b0, 16'h0, 1'b1, 1'b1, 4'd4, 16'h0034);
        step(1'b1, 16'h1534, 1'b1, 1'b0, 4'd0, 16'h0);
        check("t2_valid", 16'(ifc.out_valid), 16'h1);
        check("t2_opc", 16'(ifc.opc), 16'h1);
        check("t2_rd", 16'(ifc.rd), 16'h5);
        check("t2_op_a", ifc.op_a, 16'h0012);
        check("t2_op_b", ifc.op_b, 16'h0034);

        // r0 ignores writes, including same-cycle ones.
        step(1'b0, 16'h0, 1'b1, 1'b1, 4'd0, 16'hFFFF);
        step(1'b1, mk(OP_OR, 4'd6, 4'd0, 4'd3), 1'b1, 1'b0, 4'd0, 16'h0);
        check("t3_r0_a", ifc.op_a, 16'h0);
        check("t3_r3_b", ifc.op_b, 16'h0012);
        step(1'b1, mk(OP_AND, 4'd6, 4'd0, 4'd0), 1'b1, 1'b1, 4'd0, 16'hFFFF);
        check("t3_r0_a2", ifc.op_a, 16'h0);
        check("t3_r0_b2", ifc.op_b, 16'h0);

        // Same-cycle bypass to both operands.
        step(1'b1, mk(OP_SLT, 4'd8, 4'd7, 4'd7), 1'b1, 1'b1, 4'd7, 16'hBEEF);
        check("t4_byp_a", ifc.op_a, 16'hBEEF);
        check("t4_byp_b", ifc.op_b, 16'hBEEF);

        // Stall with writebacks to the held source register.
        step(1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 16'h0);
        step(1'b1, mk(OP_SUB, 4'd9, 4'd3, 4'd4), 1'b0, 1'b0, 4'd0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, mk(OP_SHL, 4'd10, 4'd3, 4'd3), 1'b0, 1'b1, 4'd3, 16'h0ABC + 16'(k));
            check("t5_in_ready", 16'(ifc.in_ready), 16'h0);
            check("t5_hold_valid", 16'(ifc.out_valid), 16'h1);
            check("t5_hold_op_a", ifc.op_a, 16'h0012);
            check("t5_hold_op_b", ifc.op_b, 16'h0034);
            check("t5_hold_rd", 16'(ifc.rd), 16'h9);
        end
        step(1'b1, mk(OP_SHL, 4'd10, 4'd3, 4'd3), 1'b1, 1'b0, 4'd0, 16'h0);
        check("t5_new_opc", 16'(ifc.opc), 16'h5);
        check("t5_new_rd", 16'(ifc.rd), 16'hA);
        check("t5_new_op_a", ifc.op_a, 16'h0ABE);
        check("t5_new_op_b", ifc.op_b, 16'h0ABE);

        // Back-to-back stream with random writebacks.
        for (int k = 0; k < 8; k++) begin
            ins = 16'($urandom);
            step(1'b1, ins, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 16'($urandom));
            check("t6_stream_valid", 16'(ifc.out_valid), 16'h1);
        end
        step(1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 16'h0);
        check("t6_drain_valid", 16'(ifc.out_valid), 16'h0);
        @(negedge clk);
        check("sb_empty", 16'(sb_q.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
